// File: rtl/position_tracker_pkg.sv
// Shared constants and helpers for the multi-channel stepper position tracker.
package position_tracker_pkg;

  localparam int unsigned CH_A  = 0;
  localparam int unsigned CH_B  = 1;
  localparam int unsigned CH_Z  = 2;
  localparam int unsigned CH_E1 = 3;

  localparam logic DIR_FWD = 1'b0;

  localparam int unsigned DEF_NUM_CH      = 4;
  localparam int unsigned DEF_POS_W       = 32;
  localparam int unsigned DEF_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DOWN = 2'd2
  } step_kind_e;

  function automatic logic is_forward(input logic dir, input logic inv);
    return (dir ^ inv) == DIR_FWD;
  endfunction

endpackage

// File: rtl/position_tracker_step_channel.sv
// One tracked channel: input synchronisers, step edge detect, signed counter with preset and sticky wrap flag.
module step_channel
  import position_tracker_pkg::*;
#(
  parameter int unsigned POS_W       = DEF_POS_W,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  input  logic             direction,
  input  logic             enable_n,
  input  logic             inversion,
  input  logic             load,
  input  logic [POS_W-1:0] load_value,
  input  logic             clear_ovf,
  output logic [POS_W-1:0] pos,
  output logic             step_seen,
  output logic             overflow
);

  localparam logic [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
  localparam logic [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};
  localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

  logic [SYNC_STAGES-1:0] step_sync;
  logic [SYNC_STAGES-1:0] dir_sync;
  logic [SYNC_STAGES-1:0] en_n_sync;
  logic                   step_prev;
  step_kind_e             step_req;
  logic                   wrap;

  // The qualified edge is registered together with its direction, so the
  // counter sees one step request one cycle after the edge is detected.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_sync <= '0;
      dir_sync  <= '0;
      en_n_sync <= '0;
      step_prev <= 1'b0;
      step_req  <= STEP_NONE;
    end else begin
      step_sync <= {step_sync[SYNC_STAGES-2:0], step};
      dir_sync  <= {dir_sync[SYNC_STAGES-2:0], direction};
      en_n_sync <= {en_n_sync[SYNC_STAGES-2:0], enable_n};
      step_prev <= step_sync[SYNC_STAGES-1];
      if (step_sync[SYNC_STAGES-1] && !step_prev && !en_n_sync[SYNC_STAGES-1]) begin
        step_req <= is_forward(dir_sync[SYNC_STAGES-1], inversion) ? STEP_UP : STEP_DOWN;
      end else begin
        step_req <= STEP_NONE;
      end
    end
  end

  always_comb begin
    wrap = 1'b0;
    if (!load) begin
      wrap = ((step_req == STEP_UP)   && (pos == POS_MAX)) ||
             ((step_req == STEP_DOWN) && (pos == POS_MIN));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos       <= '0;
      step_seen <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      step_seen <= 1'b0;
      if (load) begin
        pos <= load_value;
      end else if (step_req == STEP_UP) begin
        pos       <= pos + POS_ONE;
        step_seen <= 1'b1;
      end else if (step_req == STEP_DOWN) begin
        pos       <= pos - POS_ONE;
        step_seen <= 1'b1;
      end

      if (wrap) begin
        overflow <= 1'b1;
      end else if (clear_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/position_tracker.sv
// Multi-channel step position tracker with registered CoreXY (or direct) X/Y outputs.
module position_tracker
  import position_tracker_pkg::*;
#(
  parameter int unsigned NUM_CH      = DEF_NUM_CH,
  parameter int unsigned POS_W       = DEF_POS_W,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned COREXY      = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       step,
  input  logic [NUM_CH-1:0]       direction,
  input  logic [NUM_CH-1:0]       enable_n,
  input  logic [NUM_CH-1:0]       inversion,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*POS_W-1:0] load_value,
  input  logic                    clear_ovf,
  output logic [NUM_CH*POS_W-1:0] pos,
  output logic [POS_W-1:0]        pos_x,
  output logic [POS_W-1:0]        pos_y,
  output logic [NUM_CH-1:0]       step_seen,
  output logic [NUM_CH-1:0]       overflow
);

  logic [POS_W-1:0] pos_ch [NUM_CH];
  logic [POS_W:0]   sum_ab;
  logic [POS_W:0]   diff_ab;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    step_channel #(
      .POS_W      (POS_W),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .step      (step[i]),
      .direction (direction[i]),
      .enable_n  (enable_n[i]),
      .inversion (inversion[i]),
      .load      (load[i]),
      .load_value(load_value[i*POS_W +: POS_W]),
      .clear_ovf (clear_ovf),
      .pos       (pos_ch[i]),
      .step_seen (step_seen[i]),
      .overflow  (overflow[i])
    );
    assign pos[i*POS_W +: POS_W] = pos_ch[i];
  end

  // Sign-extend by one bit so the halving never loses the carry/borrow.
  always_comb begin
    sum_ab  = {pos_ch[CH_A][POS_W-1], pos_ch[CH_A]} + {pos_ch[CH_B][POS_W-1], pos_ch[CH_B]};
    diff_ab = {pos_ch[CH_A][POS_W-1], pos_ch[CH_A]} - {pos_ch[CH_B][POS_W-1], pos_ch[CH_B]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos_x <= '0;
      pos_y <= '0;
    end else if (COREXY != 0) begin
      pos_x <= sum_ab[POS_W:1];
      pos_y <= diff_ab[POS_W:1];
    end else begin
      pos_x <= pos_ch[CH_A];
      pos_y <= pos_ch[CH_B];
    end
  end

endmodule

// File: tb/tb_position_tracker.sv
// Self-checking bench for position_tracker: directed scenarios plus randomized steps against a behavioural model.
module tb_position_tracker;

  localparam int NUM_CH = 4;
  localparam int POS_W  = 32;
  localparam int SYNC   = 2;
  localparam int CA = 0, CB = 1, CZ = 2, CE = 3;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NUM_CH-1:0]       step, direction, enable_n, inversion, load;
  logic [NUM_CH*POS_W-1:0] load_value;
  logic                    clear_ovf;
  logic [NUM_CH*POS_W-1:0] pos;
  logic [POS_W-1:0]        pos_x, pos_y;
  logic [NUM_CH-1:0]       step_seen, overflow;

  position_tracker #(
    .NUM_CH     (NUM_CH),
    .POS_W      (POS_W),
    .SYNC_STAGES(SYNC),
    .COREXY     (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .step      (step),
    .direction (direction),
    .enable_n  (enable_n),
    .inversion (inversion),
    .load      (load),
    .load_value(load_value),
    .clear_ovf (clear_ovf),
    .pos       (pos),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .step_seen (step_seen),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int seen_cnt [NUM_CH];

  // Reference model state
  logic [POS_W-1:0] m_pos  [NUM_CH];
  logic             m_ovf  [NUM_CH];
  int               m_seen [NUM_CH];

  initial for (int i = 0; i < NUM_CH; i++) seen_cnt[i] = 0;

  always @(negedge clk) begin
    for (int i = 0; i < NUM_CH; i++) if (step_seen[i] === 1'b1) seen_cnt[i]++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [POS_W-1:0] chpos(input int ch);
    return pos[ch*POS_W +: POS_W];
  endfunction

  function automatic longint sval(input logic [POS_W-1:0] v);
    return longint'($signed(v));
  endfunction

  // floor((a+b)/2) and floor((a-b)/2) from plain integer arithmetic
  function automatic logic [POS_W-1:0] half_floor(input longint s);
    longint h;
    h = (s - (s & 64'sd1)) / 2;
    return POS_W'(h);
  endfunction

  function automatic void model_step(input int ch);
    longint v;
    if (enable_n[ch]) return;
    v = sval(m_pos[ch]) + (((direction[ch] ^ inversion[ch]) == 1'b0) ? 1 : -1);
    if (v > 64'sd2147483647) begin
      v -= 64'sd4294967296;
      m_ovf[ch] = 1'b1;
    end else if (v < -64'sd2147483648) begin
      v += 64'sd4294967296;
      m_ovf[ch] = 1'b1;
    end
    m_pos[ch] = POS_W'(v);
    m_seen[ch]++;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_pos[i] = '0;
      m_ovf[i] = 1'b0;
    end
  endfunction

  task automatic set_ctrl(input logic [NUM_CH-1:0] d, input logic [NUM_CH-1:0] en_n,
                          input logic [NUM_CH-1:0] inv);
    direction = d;
    enable_n  = en_n;
    inversion = inv;
    tick(SYNC + 2);
  endtask

  task automatic pulse(input logic [NUM_CH-1:0] mask);
    step = mask;
    tick(2);
    step = '0;
    tick(SYNC + 3);
    for (int i = 0; i < NUM_CH; i++) if (mask[i]) model_step(i);
  endtask

  task automatic pulses(input logic [NUM_CH-1:0] mask, input int n);
    for (int k = 0; k < n; k++) pulse(mask);
  endtask

  task automatic do_load(input int ch, input logic [POS_W-1:0] v);
    load_value[ch*POS_W +: POS_W] = v;
    load[ch] = 1'b1;
    tick(1);
    load = '0;
    tick(1);
    m_pos[ch] = v;
  endtask

  task automatic do_clear();
    clear_ovf = 1'b1;
    tick(1);
    clear_ovf = 1'b0;
    tick(1);
    for (int i = 0; i < NUM_CH; i++) m_ovf[i] = 1'b0;
  endtask

  task automatic check_all(input string tag);
    @(negedge clk);
    for (int i = 0; i < NUM_CH; i++) begin
      chk($sformatf("%s_pos%0d", tag, i), 64'(chpos(i)), 64'(m_pos[i]));
      chk($sformatf("%s_ovf%0d", tag, i), 64'(overflow[i]), 64'(m_ovf[i]));
      chk($sformatf("%s_seen%0d", tag, i), 64'(seen_cnt[i]), 64'(m_seen[i]));
    end
    chk({tag, "_x"}, 64'(pos_x), 64'(half_floor(sval(m_pos[CA]) + sval(m_pos[CB]))));
    chk({tag, "_y"}, 64'(pos_y), 64'(half_floor(sval(m_pos[CA]) - sval(m_pos[CB]))));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    logic [POS_W-1:0] old_e, old_x;
    reset      = 1'b0;
    step       = '0;
    direction  = '0;
    enable_n   = '0;
    inversion  = '0;
    load       = '0;
    load_value = '0;
    clear_ovf  = 1'b0;
    model_reset();
    for (int i = 0; i < NUM_CH; i++) m_seen[i] = 0;

    // Reset state
    tick(3);
    @(negedge clk);
    chk("rst_pos", 64'(pos), 64'd0);
    chk("rst_x", 64'(pos_x), 64'd0);
    chk("rst_y", 64'(pos_y), 64'd0);
    chk("rst_seen", 64'(step_seen), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    tick(2);

    // Reset asserted mid-count
    set_ctrl('0, '0, '0);
    pulses(4'b0001, 2);
    check_all("pre_rst");
    step = 4'b0001;
    tick(1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_pos", 64'(pos), 64'd0);
    chk("midrst_x", 64'(pos_x), 64'd0);
    chk("midrst_y", 64'(pos_y), 64'd0);
    chk("midrst_ovf", 64'(overflow), 64'd0);
    step = '0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    tick(2);
    pulses(4'b0001, 2);
    chk("after_rst_A", 64'(chpos(CA)), 64'd2);
    check_all("after_rst");

    // Direction, enable, inversion
    do_load(CA, '0);
    base = seen_cnt[CA];
    pulses(4'b0001, 10);
    set_ctrl(4'b0001, 4'b0000, 4'b0000);
    pulses(4'b0001, 4);
    set_ctrl(4'b0001, 4'b0001, 4'b0000);
    pulses(4'b0001, 3);
    @(negedge clk);
    chk("dir_en_A", 64'(chpos(CA)), 64'd6);
    chk("dir_en_seen", 64'(seen_cnt[CA] - base), 64'd14);
    set_ctrl(4'b0000, 4'b0000, 4'b0001);
    pulses(4'b0001, 2);
    chk("inv_A", 64'(chpos(CA)), 64'd4);
    check_all("dir");

    // CoreXY
    set_ctrl('0, '0, '0);
    do_load(CA, '0);
    do_load(CB, '0);
    pulses(4'b0011, 40);
    pulses(4'b0001, 60);
    @(negedge clk);
    chk("cxy_x", 64'(pos_x), 64'd70);
    chk("cxy_y", 64'(pos_y), 64'd30);
    set_ctrl(4'b0010, '0, '0);
    pulse(4'b0010);
    @(negedge clk);
    chk("cxy_x2", 64'(pos_x), 64'd69);
    chk("cxy_y2", 64'(pos_y), 64'd30);
    do_load(CA, -32'sd3);
    do_load(CB, '0);
    tick(1);
    @(negedge clk);
    chk("cxy_negx", 64'(pos_x), 64'(32'hFFFF_FFFE));
    chk("cxy_negy", 64'(pos_y), 64'(32'hFFFF_FFFE));
    check_all("cxy");

    // Wrap both ways with sticky overflow
    set_ctrl('0, '0, '0);
    do_load(CA, 32'h7FFF_FFFF);
    pulse(4'b0001);
    @(negedge clk);
    chk("wrap_up_A", 64'(chpos(CA)), 64'(32'h8000_0000));
    chk("wrap_up_ovf", 64'(overflow[CA]), 64'd1);
    tick(3);
    check_all("wrap_sticky");
    do_clear();
    @(negedge clk);
    chk("wrap_clr", 64'(overflow[CA]), 64'd0);
    set_ctrl(4'b0001, '0, '0);
    pulse(4'b0001);
    check_all("wrap_dn");
    do_clear();
    check_all("wrap_clr2");

    // Load collides with a detected Z step
    set_ctrl('0, '0, '0);
    base = seen_cnt[CZ];
    step = 4'b0100;
    tick(SYNC + 1);
    load_value[CZ*POS_W +: POS_W] = 32'd1000;
    load[CZ] = 1'b1;
    tick(1);
    load = '0;
    step = '0;
    tick(SYNC + 3);
    @(negedge clk);
    chk("coll_Z", 64'(chpos(CZ)), 64'd1000);
    chk("coll_seen", 64'(seen_cnt[CZ] - base), 64'd0);
    m_pos[CZ] = 32'd1000;
    pulse(4'b0100);
    chk("coll_next", 64'(chpos(CZ)), 64'd1001);
    check_all("coll");

    // Exact latency on E1 (and A for the kinematics lag)
    old_e = m_pos[CE];
    old_x = pos_x;
    step = 4'b1001;
    for (int j = 1; j <= SYNC + 3; j++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("lat_pos_%0d", j), 64'(chpos(CE)),
          (j >= SYNC + 2) ? 64'(old_e + 32'd1) : 64'(old_e));
      chk($sformatf("lat_seen_%0d", j), 64'(step_seen[CE]), (j == SYNC + 2) ? 64'd1 : 64'd0);
      if (j == SYNC + 2) chk("lat_x_hold", 64'(pos_x), 64'(old_x));
    end
    @(posedge clk);
    #1 step = '0;
    tick(SYNC + 3);
    model_step(CA);
    model_step(CE);
    check_all("lat");

    // Randomized steps, loads and clears
    for (int it = 0; it < 60; it++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        int ch;
        logic [POS_W-1:0] v;
        ch = int'($urandom_range(0, NUM_CH - 1));
        case ($urandom_range(0, 2))
          0:       v = 32'h7FFF_FFFF - 32'($urandom_range(0, 1));
          1:       v = 32'h8000_0000 + 32'($urandom_range(0, 1));
          default: v = 32'($urandom);
        endcase
        do_load(ch, v);
      end else if (r == 1) begin
        do_clear();
      end else begin
        logic [NUM_CH-1:0] en_n, mask;
        for (int i = 0; i < NUM_CH; i++) en_n[i] = ($urandom_range(0, 4) == 0);
        set_ctrl(4'($urandom), en_n, 4'($urandom));
        mask = 4'($urandom_range(1, 15));
        pulses(mask, int'($urandom_range(1, 3)));
      end
      check_all($sformatf("rnd%0d", it));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
